// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: sequencer state encoding and TLR walk length shared by the scan sequencer files
package jtag_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, SEL_DR1, SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, UPD_IR,
    SEL_DR2, CAP_DR, SHIFT_DR, EX1_DR, UPD_DR, TLR_WALK
  } state_t;
  localparam int TLR_LEN = 5;
endpackage

// File: rtl/jtag_bit_counter.sv
// jtag_bit_counter: loadable CNT_W-bit down-counter with zero flag; ports clk, rst_n (sync active-low), load/load_val, dec in; zero out
module jtag_bit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: one IR+DR JTAG scan per start (TCK, sync active-low TRST; start/ir_opcode/dr_length/cmp_en in; TMS/ir_tdi/ir_select/load/shift_en/strobe/busy/done out); JTAG_SEQ_TLR_EN adds a TLR walk before each scan
module jtag_scan_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int BSC_REG_SIZE = 253,
  parameter int IR_SIZE      = 4,
  parameter int CNT_W        = 8
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               start,
  input  logic [IR_SIZE-1:0] ir_opcode,
  input  logic [CNT_W-1:0]   dr_length,
  input  logic               cmp_en,
  output logic               TMS,
  output logic               ir_tdi,
  output logic               ir_select,
  output logic               load,
  output logic               shift_en,
  output logic               strobe,
  output logic               busy,
  output logic               done
);
  state_t state, next_state;
  logic [IR_SIZE-1:0] ir_sr;
  logic [CNT_W-1:0] len_q, len_m1, cnt_val;
  logic cmp_q, cnt_load, cnt_dec, cnt_zero;
  assign len_m1 = (len_q == '0) ? '0 :
                  (len_q > CNT_W'(BSC_REG_SIZE)) ? CNT_W'(BSC_REG_SIZE - 1) : len_q - CNT_W'(1);
  jtag_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (TCK),
    .rst_n    (TRST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );
  always_comb begin
    next_state = state;
    TMS        = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        TMS = start;
`ifdef JTAG_SEQ_TLR_EN
        next_state = start ? TLR_WALK : IDLE;
        cnt_load   = start;
        cnt_val    = CNT_W'(TLR_LEN);
`else
        next_state = start ? SEL_DR1 : IDLE;
`endif
      end
`ifdef JTAG_SEQ_TLR_EN
      TLR_WALK: begin
        TMS        = !cnt_zero;
        cnt_dec    = !cnt_zero;
        next_state = cnt_zero ? SEL_DR1 : TLR_WALK;
      end
`endif
      SEL_DR1: begin
        TMS        = 1'b1;
        next_state = SEL_IR;
      end
      SEL_IR: next_state = CAP_IR;
      CAP_IR: begin
        cnt_load   = 1'b1;
        cnt_val    = CNT_W'(IR_SIZE - 1);
        next_state = SHIFT_IR;
      end
      SHIFT_IR: begin
        TMS        = cnt_zero;
        cnt_dec    = !cnt_zero;
        next_state = cnt_zero ? EX1_IR : SHIFT_IR;
      end
      EX1_IR: begin
        TMS        = 1'b1;
        next_state = UPD_IR;
      end
      UPD_IR: begin
        TMS        = 1'b1;
        next_state = SEL_DR2;
      end
      SEL_DR2: next_state = CAP_DR;
      CAP_DR: begin
        cnt_load   = 1'b1;
        cnt_val    = len_m1;
        next_state = SHIFT_DR;
      end
      SHIFT_DR: begin
        TMS        = cnt_zero;
        cnt_dec    = !cnt_zero;
        next_state = cnt_zero ? EX1_DR : SHIFT_DR;
      end
      EX1_DR: begin
        TMS        = 1'b1;
        next_state = UPD_DR;
      end
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge TCK)
    if (!TRST) begin
      state <= IDLE;
      ir_sr <= '0;
      len_q <= '0;
      cmp_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        ir_sr <= ir_opcode;
        len_q <= dr_length;
        cmp_q <= cmp_en;
      end else if (state == SHIFT_IR) ir_sr <= ir_sr >> 1;
    end
  assign ir_select = state == CAP_IR || state == SHIFT_IR || state == EX1_IR;
  assign ir_tdi    = ir_select & ir_sr[0];
  assign load      = state == CAP_DR;
  assign shift_en  = state == SHIFT_DR;
  assign strobe    = cmp_q && (state == SHIFT_DR || state == EX1_DR);
  assign busy      = state != IDLE;
  assign done      = state == UPD_DR;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: randomized scans checked cycle by cycle against a timeline model of the scan sequence
module tb_jtag_scan_sequencer;
  localparam int IR = 4;
  localparam int BSC = 253;
`ifdef JTAG_SEQ_TLR_EN
  localparam int W = 6;
`else
  localparam int W = 0;
`endif
  logic TCK = 1'b0, TRST, start, cmp_en;
  logic [IR-1:0] ir_opcode;
  logic [7:0] dr_length;
  logic TMS, ir_tdi, ir_select, load, shift_en, strobe, busy, done;
  int vectors = 0, errs = 0;

  jtag_scan_sequencer #(.BSC_REG_SIZE(BSC), .IR_SIZE(IR), .CNT_W(8)) dut (
    .TCK(TCK), .TRST(TRST), .start(start), .ir_opcode(ir_opcode), .dr_length(dr_length),
    .cmp_en(cmp_en), .TMS(TMS), .ir_tdi(ir_tdi), .ir_select(ir_select), .load(load),
    .shift_en(shift_en), .strobe(strobe), .busy(busy), .done(done)
  );

  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {TMS, ir_select, ir_tdi, load, shift_en, strobe, busy, done};
  endfunction

  function automatic int clamp(input logic [7:0] len);
    return len == 0 ? 1 : (int'(len) > BSC ? BSC : int'(len));
  endfunction

  // {compare mask, expected outputs} for cycle k after the cycle in which start was accepted
  function automatic logic [15:0] model(input int k, input logic [IR-1:0] op, input int L, input logic c);
    int j;
    logic [7:0] e;
    if (k >= 1 && k <= W) return {8'hDF, 1'(k < W), 5'b0, 1'b1, 1'b0};
    j = k == 0 ? 0 : k - W;
    e[7] = j <= 1 || (j >= 3 + IR && j <= 5 + IR) || j == 7 + IR + L || j == 8 + IR + L;
    e[6] = j >= 3 && j <= 4 + IR;
    e[5] = (j >= 4 && j <= 3 + IR) ? op[j-4] : 1'b0;
    e[4] = j == 7 + IR;
    e[3] = j >= 8 + IR && j <= 7 + IR + L;
    e[2] = c && j >= 8 + IR && j <= 8 + IR + L;
    e[1] = j >= 1 && j <= 9 + IR + L;
    e[0] = j == 9 + IR + L;
    return {(j >= 4 && j <= 3 + IR) ? 8'hFF : 8'hDF, e};
  endfunction

  task automatic run_txn(input string tag, input logic [IR-1:0] op, input logic [7:0] len,
                         input logic c, input int lock_k, input int rst_k);
    int L, n;
    logic [15:0] me;
    L = clamp(len);
    n = W + 10 + IR + L;
    @(negedge TCK);
    start = 1'b1; ir_opcode = op; dr_length = len; cmp_en = c;
    #1 me = model(0, op, L, c);
    check({tag, "_c0"}, obs() & me[15:8], me[7:0] & me[15:8]);
    for (int k = 1; k < n; k++) begin
      @(negedge TCK);
      start = k == lock_k;
      ir_opcode = IR'($urandom);
      dr_length = 8'($urandom);
      cmp_en = 1'($urandom);
      #1 me = model(k, op, L, c);
      check($sformatf("%s_c%0d", tag, k), obs() & me[15:8], me[7:0] & me[15:8]);
      if (k == rst_k) begin
        start = 1'b0;
        TRST = 1'b0;
        @(negedge TCK);
        #1 check({tag, "_abort"}, obs(), 8'h00);
        TRST = 1'b1;
        repeat (3) begin
          @(negedge TCK);
          #1 check({tag, "_post_rst"}, obs(), 8'h00);
        end
        return;
      end
    end
    @(negedge TCK);
    start = 1'b0;
    #1 check({tag, "_idle"}, obs(), 8'h00);
  endtask

  initial begin
    TRST = 1'b0; start = 1'b0; ir_opcode = '0; dr_length = '0; cmp_en = 1'b0;
    repeat (2) @(negedge TCK);
    #1 check("reset", obs(), 8'h00);
    TRST = 1'b1;
    run_txn("basic", 4'b1011, 8'd8, 1'b1, -1, -1);
    run_txn("len0", 4'b0110, 8'd0, 1'b1, -1, -1);
    run_txn("len255", 4'b1001, 8'd255, 1'b1, -1, -1);
    run_txn("len253", 4'b0011, 8'd253, 1'b0, -1, -1);
    run_txn("nocmp", 4'b1100, 8'd16, 1'b0, -1, -1);
    run_txn("cmp16", 4'b1100, 8'd16, 1'b1, -1, -1);
    run_txn("lockout", 4'b0101, 8'd5, 1'b1, W + 5, -1);
    run_txn("midrst", 4'b1110, 8'd10, 1'b1, -1, W + 14);
    run_txn("after_rst", 4'b0111, 8'd3, 1'b1, -1, -1);
    for (int t = 0; t < 20; t++)
      run_txn($sformatf("rnd%0d", t), IR'($urandom), 8'($urandom_range(0, 255)), 1'($urandom),
              $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 12)) : -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
